// File: rtl/div_iter_16by8.sv
// div_iter_16by8: iterative restoring divider, 2*size-bit dividend by size-bit divisor.
// Retires one quotient bit per clock, MSB first, with an enable-in/enable-out handshake.
// Optional build macro: DIV_ZERO_DETECT_EN.
//   Defined:   a zero divisor completes one cycle after acceptance and raises div_by_zero.
//   Undefined: a zero divisor runs the full iteration, and div_by_zero stays 0.
// In both builds a zero divisor yields quotient all-ones and remainder div_a[size-1:0].
module div_iter_16by8 #(
    parameter int size = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_en_in,
    input  logic [2*size-1:0]   div_a,
    input  logic [size-1:0]     div_b,
    output logic                div_ready,
    output logic                div_en_out,
    output logic [2*size-1:0]   div_quo,
    output logic [size-1:0]     div_rem,
    output logic                div_by_zero
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    localparam int CW = $clog2(2*size);
    localparam logic [CW-1:0] LAST_ITER = CW'(2*size-1);

    logic [0:0]          state_reg;
    // Holds the dividend; quotient bits are shifted in at the LSB as dividend bits leave the MSB.
    logic [2*size-1:0]   dvd_reg;
    logic [size-1:0]     dvs_reg;
    // Partial remainder. Its top bit is always 0 after a step because R < divisor,
    // so only the low size bits are stored.
    logic [size-1:0]     part_reg;
    logic [CW-1:0]       count_reg;

    logic [2*size-1:0]   div_quo_reg;
    logic [size-1:0]     div_rem_reg;
    logic                div_by_zero_reg;
    logic                div_en_out_reg;

    logic [size:0]       part_shift;
    logic                quo_bit;
    logic [size-1:0]     part_diff;
    logic [size-1:0]     part_next;
    logic [2*size-1:0]   dvd_next;
    logic                zero_hit;

`ifdef DIV_ZERO_DETECT_EN
    logic                zero_reg;

    // Remember whether the accepted divisor was zero so CALC can finish immediately.
    always_ff @(posedge clk) begin
        if (rst)
            zero_reg <= 1'b0;
        else if (state_reg == IDLE && div_en_in)
            zero_reg <= (div_b == '0);
    end

    assign zero_hit = zero_reg;
`else
    assign zero_hit = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    // When part_shift[size] is set the value already exceeds any divisor; the modular
    // difference of the low bits is still exact because the result is below the divisor.
    always_comb begin
        part_shift = {part_reg, dvd_reg[2*size-1]};
        quo_bit    = part_shift[size] | (part_shift[size-1:0] >= dvs_reg);
        part_diff  = part_shift[size-1:0] - dvs_reg;
        part_next  = quo_bit ? part_diff : part_shift[size-1:0];
        dvd_next   = {dvd_reg[2*size-2:0], quo_bit};
    end

    // Control FSM, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            dvd_reg         <= '0;
            dvs_reg         <= '0;
            part_reg        <= '0;
            count_reg       <= '0;
            div_quo_reg     <= '0;
            div_rem_reg     <= '0;
            div_by_zero_reg <= 1'b0;
            div_en_out_reg  <= 1'b0;
        end else begin
            div_en_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (div_en_in) begin
                        dvd_reg   <= div_a;
                        dvs_reg   <= div_b;
                        part_reg  <= '0;
                        count_reg <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    if (zero_hit) begin
                        div_quo_reg     <= '1;
                        div_rem_reg     <= dvd_reg[size-1:0];
                        div_by_zero_reg <= 1'b1;
                        div_en_out_reg  <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        dvd_reg   <= dvd_next;
                        part_reg  <= part_next;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_ITER) begin
                            div_quo_reg     <= dvd_next;
                            div_rem_reg     <= part_next;
                            div_by_zero_reg <= 1'b0;
                            div_en_out_reg  <= 1'b1;
                            state_reg       <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign div_ready   = (state_reg == IDLE);
    assign div_en_out  = div_en_out_reg;
    assign div_quo     = div_quo_reg;
    assign div_rem     = div_rem_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_div_iter_16by8.sv
// Scoreboard bench for div_iter_16by8: a cycle-level model of acceptance pushes the
// expected result (from plain / and %) into a queue; a negedge monitor checks it.
module tb_div_iter_16by8;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        div_en_in;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic        div_ready;
    logic        div_en_out;
    logic [15:0] div_quo;
    logic [7:0]  div_rem;
    logic        div_by_zero;

    always #5 clk = ~clk;

    div_iter_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .div_en_in   (div_en_in),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_ready   (div_ready),
        .div_en_out  (div_en_out),
        .div_quo     (div_quo),
        .div_rem     (div_rem),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] quo;
        logic [7:0]  rem;
        logic        bz;
        int          done;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    logic model_ready = 1'b1;
    int   busy_cnt = 0;
    logic rst_seen = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    // Expected result and completion edge for a request accepted at edge c.
    function automatic exp_t model_of(input logic [15:0] a, input logic [7:0] b, input int c);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 8'd0) begin
            e.quo  = 16'hFFFF;
            e.rem  = a[7:0];
            e.bz   = ZD;
            e.done = c + (ZD ? 1 : 16);
        end else begin
            e.quo  = 16'(int'(a) / int'(b));
            e.rem  = 8'(int'(a) % int'(b));
            e.bz   = 1'b0;
            e.done = c + 16;
        end
        return e;
    endfunction

    // Acceptance model: decides at each rising edge whether a request is taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            rst_seen = rst;
            if (rst) begin
                sb_q.delete();
                model_ready = 1'b1;
                busy_cnt = 0;
            end else if (model_ready && div_en_in) begin
                e = model_of(div_a, div_b, cyc);
                sb_q.push_back(e);
                model_ready = 1'b0;
                busy_cnt = e.done - cyc;
            end else if (!model_ready) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) model_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: compares DUT outputs against the model on every falling edge.
    initial begin
        exp_t e;
        logic exp_pulse;
        forever begin
            @(negedge clk);
            chk("div_ready", 32'(div_ready), 32'(model_ready));
            exp_pulse = (sb_q.size() > 0) && (sb_q[0].done == cyc);
            chk("div_en_out", 32'(div_en_out), 32'(exp_pulse));
            if (exp_pulse) begin
                e = sb_q.pop_front();
                $display("txn %0d / %0d -> quo=%0d rem=%0d dz=%0b (want %0d %0d %0b)",
                         e.a, e.b, div_quo, div_rem, div_by_zero, e.quo, e.rem, e.bz);
                chk("div_quo", 32'(div_quo), 32'(e.quo));
                chk("div_rem", 32'(div_rem), 32'(e.rem));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.bz));
                if (e.b != 8'd0) begin
                    chk("identity", 32'(int'(div_quo) * int'(e.b) + int'(div_rem)), 32'(e.a));
                    chk("rem_lt_b", 32'(div_rem < e.b), 32'd1);
                end
            end
            if (rst_seen)
                chk("reset_outputs", {div_quo, div_rem, 7'd0, div_by_zero}, 32'd0);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!model_ready) begin
            @(negedge clk);
            n = n + 1;
            if (n > 100) begin
                $display("FAIL wait_ready: model never idle, got busy, expected idle");
                $fatal(1, "bench stalled");
            end
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] b);
        wait_ready();
        div_en_in = 1'b1;
        div_a = a;
        div_b = b;
        @(negedge clk);
        div_en_in = 1'b0;
        div_a = 16'($urandom);
        div_b = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        div_en_in = 1'b0;
        div_a = '0;
        div_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(16'd1000, 8'd7);
        send(16'hFFFF, 8'hFF);
        send(16'hFFFF, 8'd1);
        send(16'd200, 8'd201);
        send(16'd0, 8'd5);
        send(16'h1234, 8'd0);

        // Request held high with operands changing every cycle.
        wait_ready();
        div_en_in = 1'b1;
        for (int i = 0; i < 3 * 17 + 1; i++) begin
            div_a = 16'($urandom);
            div_b = 8'($urandom_range(1, 255));
            @(negedge clk);
        end
        div_en_in = 1'b0;

        // Reset at the eighth edge of a division aborts it.
        wait_ready();
        div_en_in = 1'b1;
        div_a = 16'd4321;
        div_b = 8'd13;
        @(negedge clk);
        div_en_in = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(16'd60000, 8'd250);

        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 7)
                send(16'($urandom), 8'd0);
            else if (i % 3 == 0)
                send(16'($urandom), 8'($urandom_range(1, 15)));
            else
                send(16'($urandom), 8'($urandom_range(1, 255)));
            if (i % 11 == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
